schedule_queue: RTL and testbench
=================================

Name: schedule_queue

Overview:
- Parametrised successor to the single-register schedule stage. Sits between decode stage 2 (CHECK_*) and execute (SCHEDULE_*).
- Buffers up to DEPTH decoded instruction bundles in a FIFO with valid/ready handshakes on both sides.
- Honours FLUSH, STALL and MEM_WAIT, and reports occupancy and an almost-full level for front-end throttling.

Parameters:
DEPTH, 4, number of bundle entries; power of two, >= 2
XLEN, 32, width of PC and IMM fields
AF_LEVEL, DEPTH-1, occupancy at or above which ALMOST_FULL asserts; 1..DEPTH

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  reset, synchronous, active-low
FLUSH  in  1  discard all entries
STALL  in  1  pipeline stall; blocks dequeue only
MEM_WAIT  in  1  memory wait; blocks dequeue only
CHECK_VALID  in  1  decode offers a bundle
CHECK_READY  out  1  queue accepts a bundle
CHECK_PC  in  XLEN  bundle PC
CHECK_OPCODE  in  7  opcode
CHECK_RD  in  5  destination register
CHECK_CSR  in  12  CSR address
CHECK_FUNCT3  in  3  funct3
CHECK_FUNCT7  in  7  funct7
CHECK_IMM  in  XLEN  immediate
SCHEDULE_VALID  out  1  head bundle valid
SCHEDULE_READY  in  1  execute takes head bundle
SCHEDULE_PC/OPCODE/RD/CSR/FUNCT3/FUNCT7/IMM  out  XLEN/7/5/12/3/7/XLEN  head bundle fields
COUNT  out  $clog2(DEPTH)+1  current occupancy
ALMOST_FULL  out  1  COUNT >= AF_LEVEL

Behaviour:
- Reset (RST_N=0 at a rising edge): read/write pointers and COUNT go to 0.
- After reset: SCHEDULE_VALID=0, CHECK_READY=1, ALMOST_FULL=0, all SCHEDULE_* fields 0.
- Entry storage is not reset.
- push = CHECK_VALID && CHECK_READY && !FLUSH.
- CHECK_READY = (COUNT != DEPTH), registered-state only. A full queue never accepts, even if a pop happens in the same cycle.
- pop = SCHEDULE_VALID && SCHEDULE_READY && !STALL && !MEM_WAIT.
- STALL and MEM_WAIT freeze the head but do not block push.
- SCHEDULE_VALID = (COUNT != 0).
- SCHEDULE_* = head entry when valid, else all-zero. An all-zero bundle is the pipeline bubble.
- Latency: a bundle pushed at edge N is visible on SCHEDULE_* from edge N onward (registered), if the queue was empty. There is no combinational CHECK_* to SCHEDULE_* path.
- Simultaneous push and pop: COUNT unchanged, both pointers advance.
- Order is strict FIFO. Pointers are $clog2(DEPTH) bits and wrap naturally mod DEPTH.
- FLUSH: at the edge, pointers and COUNT go to 0. Any same-cycle push or pop is ignored. Next cycle SCHEDULE_VALID=0 and fields are 0.
- Priority: RST_N=0 > FLUSH > push/pop.
- Reset asserted mid-operation discards all entries exactly as FLUSH does.
- Pop on empty and push on full are impossible by construction; COUNT never exceeds DEPTH or underflows.
- ALMOST_FULL is combinational from COUNT.

Test Plan:
- Reset, then push PC=0x100,0x104,0x108 on consecutive cycles, SCHEDULE_READY=1 -> SCHEDULE_PC shows 0x100,0x104,0x108 in order, one cycle after each push; COUNT peaks at 1.
- SCHEDULE_READY=0, push 4 bundles (DEPTH=4) -> COUNT=4, CHECK_READY=0, ALMOST_FULL=1 from COUNT=3. A 5th offer (PC=0x200) is not accepted and never appears.
- Full queue, assert STALL with SCHEDULE_READY=1 for 3 cycles -> head PC unchanged and COUNT=4. Deassert STALL -> 4 pops over 4 cycles, then SCHEDULE_VALID=0 and all fields 0.
- Repeat with MEM_WAIT=1 instead of STALL -> same freeze. Push into a non-full queue during MEM_WAIT is accepted (COUNT increments).
- COUNT=3, assert FLUSH together with CHECK_VALID=1 (PC=0x300) -> next cycle COUNT=0, SCHEDULE_VALID=0, and 0x300 is never output.
- Push/pop continuously for 10 cycles with DEPTH=4 (pointer wrap) -> outputs match input order exactly. Then assert RST_N=0 with COUNT=2 -> next cycle COUNT=0 and CHECK_READY=1.

Source files
------------

// File: rtl/schedule_queue.sv
// schedule_queue: a FIFO of decoded instruction bundles between decode stage 2
// (check_*) and execute (schedule_*). It has valid/ready handshakes on both
// sides. flush discards every entry. stall and mem_wait freeze the head but do
// not block enqueue. count and almost_full let the front end throttle fetch.
module schedule_queue #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        stall,
  input  logic                        mem_wait,

  input  logic                        check_valid,
  output logic                        check_ready,
  input  logic [XLEN-1:0]             check_pc,
  input  logic [6:0]                  check_opcode,
  input  logic [4:0]                  check_rd,
  input  logic [11:0]                 check_csr,
  input  logic [2:0]                  check_funct3,
  input  logic [6:0]                  check_funct7,
  input  logic [XLEN-1:0]             check_imm,

  output logic                        schedule_valid,
  input  logic                        schedule_ready,
  output logic [XLEN-1:0]             schedule_pc,
  output logic [6:0]                  schedule_opcode,
  output logic [4:0]                  schedule_rd,
  output logic [11:0]                 schedule_csr,
  output logic [2:0]                  schedule_funct3,
  output logic [6:0]                  schedule_funct7,
  output logic [XLEN-1:0]             schedule_imm,

  output logic [$clog2(DEPTH):0]      count,
  output logic                        almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One decoded bundle, stored as a single word per entry.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [11:0]     csr;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } bundle_t;

  bundle_t            entries [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   occ;

  bundle_t            in_bundle;
  bundle_t            head;
  logic               push;
  logic               pop;

  // Readiness and validity depend only on registered occupancy. A full queue
  // therefore refuses an offer even when the head leaves in the same cycle.
  // This keeps check_ready free of any path from schedule_ready.
  assign check_ready    = (occ != CNT_W'(DEPTH));
  assign schedule_valid = (occ != '0);

  // Neither handshake fires while flush is high. Full and empty gate push and
  // pop, so occupancy cannot overflow or underflow.
  assign push = check_valid && check_ready && !flush;
  assign pop  = schedule_valid && schedule_ready && !stall && !mem_wait;

  assign in_bundle = '{
    pc:     check_pc,
    opcode: check_opcode,
    rd:     check_rd,
    csr:    check_csr,
    funct3: check_funct3,
    funct7: check_funct7,
    imm:    check_imm
  };

  // Write the offered bundle into the tail slot on an accepted push.
  // NOTE: entry storage has no reset. Empty slots are never observable,
  // because the output mux drives zeros whenever the queue is empty, so a
  // reset here would only add fan-out on a wide array.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= in_bundle;
    end
  end

  // Pointer and occupancy bookkeeping. Priority is reset, then flush, then the
  // handshakes.
  // NOTE: every register here uses non-blocking assignment. Each branch then
  // reads the pre-edge values of rd_ptr, wr_ptr and occ, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Present the head entry when the queue is valid. Otherwise present an
  // all-zero bubble.
  // NOTE: head is given its default before the conditional. Every path then
  // assigns it, so no latch is inferred.
  always_comb begin
    head = '0;
    if (schedule_valid) begin
      head = entries[rd_ptr];
    end
  end

  assign schedule_pc     = head.pc;
  assign schedule_opcode = head.opcode;
  assign schedule_rd     = head.rd;
  assign schedule_csr    = head.csr;
  assign schedule_funct3 = head.funct3;
  assign schedule_funct7 = head.funct7;
  assign schedule_imm    = head.imm;

  assign count       = occ;
  assign almost_full = (occ >= CNT_W'(AF_LEVEL));

endmodule

// File: tb/tb_schedule_queue.sv
// tb_schedule_queue: directed stimulus against a queue-based reference model.
// The model holds bundles in a SystemVerilog queue and applies the handshake
// rules at each rising edge. A compare process checks every DUT output against
// the model on the falling edge. The stimulus also checks a few hand-computed
// literal values, which pin the model itself.
module tb_schedule_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [11:0]     csr;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } bundle_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            stall = 1'b0;
  logic            mem_wait = 1'b0;
  logic            check_valid = 1'b0;
  logic            check_ready;
  logic [XLEN-1:0] check_pc = '0;
  logic [6:0]      check_opcode = '0;
  logic [4:0]      check_rd = '0;
  logic [11:0]     check_csr = '0;
  logic [2:0]      check_funct3 = '0;
  logic [6:0]      check_funct7 = '0;
  logic [XLEN-1:0] check_imm = '0;
  logic            schedule_valid;
  logic            schedule_ready = 1'b0;
  logic [XLEN-1:0] schedule_pc;
  logic [6:0]      schedule_opcode;
  logic [4:0]      schedule_rd;
  logic [11:0]     schedule_csr;
  logic [2:0]      schedule_funct3;
  logic [6:0]      schedule_funct7;
  logic [XLEN-1:0] schedule_imm;
  logic [CW-1:0]   count;
  logic            almost_full;

  int checks = 0;
  int errors = 0;

  bundle_t mq[$];
  bit      model_ok = 0;
  bit      seen_200 = 0;
  bit      seen_300 = 0;

  schedule_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AF_LEVEL(DEPTH - 1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .mem_wait(mem_wait),
    .check_valid(check_valid), .check_ready(check_ready),
    .check_pc(check_pc), .check_opcode(check_opcode), .check_rd(check_rd),
    .check_csr(check_csr), .check_funct3(check_funct3),
    .check_funct7(check_funct7), .check_imm(check_imm),
    .schedule_valid(schedule_valid), .schedule_ready(schedule_ready),
    .schedule_pc(schedule_pc), .schedule_opcode(schedule_opcode),
    .schedule_rd(schedule_rd), .schedule_csr(schedule_csr),
    .schedule_funct3(schedule_funct3), .schedule_funct7(schedule_funct7),
    .schedule_imm(schedule_imm), .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every field of a bundle is derived from its PC, so field mix-ups show up.
  function automatic bundle_t make_bundle(input logic [XLEN-1:0] pc);
    bundle_t b;
    b.pc     = pc;
    b.opcode = pc[6:0] ^ 7'h33;
    b.rd     = pc[8:4] ^ 5'h15;
    b.csr    = pc[11:0] ^ 12'hABC;
    b.funct3 = pc[4:2] + 3'd1;
    b.funct7 = pc[10:4] ^ 7'h5A;
    b.imm    = ~pc;
    return b;
  endfunction

  task automatic offer(input logic v, input logic [XLEN-1:0] pc);
    bundle_t b;
    b = make_bundle(pc);
    check_valid  = v;
    check_pc     = b.pc;
    check_opcode = b.opcode;
    check_rd     = b.rd;
    check_csr    = b.csr;
    check_funct3 = b.funct3;
    check_funct7 = b.funct7;
    check_imm    = b.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: apply reset, flush and the handshake rules at each edge.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      mq.delete();
      model_ok = 1;
    end else if (model_ok) begin
      if (flush) begin
        mq.delete();
      end else begin
        do_pop  = (mq.size() != 0) && schedule_ready && !stall && !mem_wait;
        do_push = check_valid && (mq.size() != DEPTH);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(make_bundle(check_pc));
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    bundle_t exp_b;
    if (model_ok) begin
      exp_b = (mq.size() != 0) ? mq[0] : '0;
      check("count", 64'(count), 64'(mq.size()));
      check("schedule_valid", 64'(schedule_valid), 64'(mq.size() != 0));
      check("check_ready", 64'(check_ready), 64'(mq.size() != DEPTH));
      check("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - 1));
      check("schedule_pc", 64'(schedule_pc), 64'(exp_b.pc));
      check("schedule_opcode", 64'(schedule_opcode), 64'(exp_b.opcode));
      check("schedule_rd", 64'(schedule_rd), 64'(exp_b.rd));
      check("schedule_csr", 64'(schedule_csr), 64'(exp_b.csr));
      check("schedule_funct3", 64'(schedule_funct3), 64'(exp_b.funct3));
      check("schedule_funct7", 64'(schedule_funct7), 64'(exp_b.funct7));
      check("schedule_imm", 64'(schedule_imm), 64'(exp_b.imm));
      if (schedule_valid && schedule_pc == 32'h200) seen_200 = 1;
      if (schedule_valid && schedule_pc == 32'h300) seen_300 = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("lit_reset_count", 64'(count), 64'd0);
    check("lit_reset_ready", 64'(check_ready), 64'd1);
    check("lit_reset_valid", 64'(schedule_valid), 64'd0);
    check("lit_reset_af", 64'(almost_full), 64'd0);
    check("lit_reset_pc", 64'(schedule_pc), 64'd0);

    // Streaming: each bundle is visible right after its push edge.
    schedule_ready = 1'b1;
    offer(1'b1, 32'h100); step();
    check("lit_stream_pc0", 64'(schedule_pc), 64'h100);
    check("lit_stream_cnt0", 64'(count), 64'd1);
    offer(1'b1, 32'h104); step();
    check("lit_stream_pc1", 64'(schedule_pc), 64'h104);
    check("lit_stream_cnt1", 64'(count), 64'd1);
    offer(1'b1, 32'h108); step();
    check("lit_stream_pc2", 64'(schedule_pc), 64'h108);
    offer(1'b0, 32'h0); step();
    check("lit_stream_empty", 64'(count), 64'd0);

    // Fill to full. A fifth offer is refused.
    schedule_ready = 1'b0;
    offer(1'b1, 32'h10); step();
    offer(1'b1, 32'h14); step();
    check("lit_af_at2", 64'(almost_full), 64'd0);
    offer(1'b1, 32'h18); step();
    check("lit_af_at3", 64'(almost_full), 64'd1);
    offer(1'b1, 32'h1c); step();
    offer(1'b1, 32'h200); step(); step();
    check("lit_full_count", 64'(count), 64'd4);
    check("lit_full_ready", 64'(check_ready), 64'd0);
    check("lit_full_head", 64'(schedule_pc), 64'h10);

    // Stall freezes the head. Releasing it drains the queue.
    offer(1'b0, 32'h0);
    stall = 1'b1;
    schedule_ready = 1'b1;
    step(); step(); step();
    check("lit_stall_head", 64'(schedule_pc), 64'h10);
    check("lit_stall_count", 64'(count), 64'd4);
    stall = 1'b0;
    step();
    check("lit_drain_head", 64'(schedule_pc), 64'h14);
    step(); step(); step();
    check("lit_drain_valid", 64'(schedule_valid), 64'd0);
    check("lit_drain_imm", 64'(schedule_imm), 64'd0);

    // mem_wait freezes the head but still accepts a push.
    schedule_ready = 1'b0;
    offer(1'b1, 32'h20); step();
    offer(1'b1, 32'h24); step();
    offer(1'b1, 32'h28); step();
    mem_wait = 1'b1;
    schedule_ready = 1'b1;
    offer(1'b1, 32'h2c); step();
    check("lit_memwait_push", 64'(count), 64'd4);
    offer(1'b0, 32'h0); step(); step();
    check("lit_memwait_head", 64'(schedule_pc), 64'h20);
    mem_wait = 1'b0;
    step(); step(); step(); step();
    check("lit_memwait_drained", 64'(count), 64'd0);

    // Flush with a same-cycle offer.
    schedule_ready = 1'b0;
    offer(1'b1, 32'h30); step();
    offer(1'b1, 32'h34); step();
    offer(1'b1, 32'h38); step();
    flush = 1'b1;
    offer(1'b1, 32'h300); step();
    flush = 1'b0;
    check("lit_flush_count", 64'(count), 64'd0);
    check("lit_flush_valid", 64'(schedule_valid), 64'd0);
    offer(1'b0, 32'h0); step();

    // Continuous push and pop across pointer wrap.
    schedule_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'h400 + 32'(4 * i)); step();
      check("lit_wrap_head", 64'(schedule_pc), 64'(32'h400 + 32'(4 * i)));
    end
    schedule_ready = 1'b0;
    offer(1'b1, 32'h500); step();
    check("lit_prereset_count", 64'(count), 64'd2);

    // Reset mid-operation discards the entries.
    offer(1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("lit_midreset_count", 64'(count), 64'd0);
    check("lit_midreset_ready", 64'(check_ready), 64'd1);
    step();

    check("never_saw_0x200", 64'(seen_200), 64'd0);
    check("never_saw_0x300", 64'(seen_300), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
